// File: rtl/bp_update_sched.sv
`default_nettype none
// ============================================================================
//  Module   : bp_update_sched
//  Purpose  : Write sequencer for the branch-predictor 2-bit counter table.
//             - Buffers ROB commit outcomes in a small FIFO.
//             - Drains the FIFO into the single table write port with
//               saturating read-modify-write updates, one per cycle.
//             - Sweeps every entry to INIT_STATE after reset or on clr_req.
//  Macro    : BP_UPD_BYPASS_EN. When defined, an update that arrives while
//             the FIFO is empty in RUN is written in the same cycle.
//  Ports    : clk, rst (sync, active-low), rdy (0 = freeze)
//             upd_valid/upd_pc/upd_taken/upd_ready : commit update stream
//             clr_req                              : full-table reinit pulse
//             tbl_rd_idx/tbl_rd_state              : combinational table read
//             tbl_wr_en/tbl_wr_idx/tbl_wr_state    : table write port
//             busy                                 : sweep in progress
//  Revision : 1.0  initial release
// ============================================================================
module bp_update_sched #(
    parameter int         IDX_W      = 12,
    parameter int         FIFO_DEPTH = 4,
    parameter logic [1:0] INIT_STATE = 2'b01
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rdy,
    input  logic             upd_valid,
    input  logic [31:0]      upd_pc,
    input  logic             upd_taken,
    output logic             upd_ready,
    input  logic             clr_req,
    output logic [IDX_W-1:0] tbl_rd_idx,
    input  logic [1:0]       tbl_rd_state,
    output logic             tbl_wr_en,
    output logic [IDX_W-1:0] tbl_wr_idx,
    output logic [1:0]       tbl_wr_state,
    output logic             busy
);

    localparam int c_ptr_w = $clog2(FIFO_DEPTH);
    localparam int c_cnt_w = c_ptr_w + 1;

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    state_t             r_state;
    logic [IDX_W-1:0]   r_clr_cnt;
    logic [IDX_W-1:0]   r_fifo_idx   [FIFO_DEPTH];
    logic               r_fifo_taken [FIFO_DEPTH];
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [c_cnt_w-1:0] r_count;

    logic [IDX_W-1:0]   w_upd_idx;
    logic               w_active;
    logic               w_full;
    logic               w_empty;
    logic               w_accept;
    logic               w_push;
    logic               w_pop;
    logic               w_unused_pc_bits;

    // Word-aligned PCs: drop the byte offset, keep IDX_W index bits.
    assign w_upd_idx        = upd_pc[IDX_W+1:2];
    assign w_unused_pc_bits = ^{upd_pc[31:IDX_W+2], upd_pc[1:0]};

    assign w_active = rst && rdy;
    assign w_full   = (r_count == c_cnt_w'(FIFO_DEPTH));
    assign w_empty  = (r_count == '0);

    function automatic logic [1:0] sat_step(input logic [1:0] cur, input logic taken);
        if (taken) begin
            return (cur == 2'b11) ? 2'b11 : cur + 2'b01;
        end
        return (cur == 2'b00) ? 2'b00 : cur - 2'b01;
    endfunction

    always_comb begin
        upd_ready    = 1'b0;
        tbl_rd_idx   = '0;
        tbl_wr_en    = 1'b0;
        tbl_wr_idx   = '0;
        tbl_wr_state = 2'b00;
        busy         = !rst || (r_state == ST_CLEAR);
        w_accept     = 1'b0;
        w_push       = 1'b0;
        w_pop        = 1'b0;

        if (w_active) begin
            // Ready ignores a same-cycle pop so it never depends on the table read.
            upd_ready = !w_full && !clr_req;
            w_accept  = upd_valid && upd_ready;

            // clr_req suppresses every write and push this cycle.
            if (!clr_req) begin
                if (r_state == ST_CLEAR) begin
                    tbl_wr_en    = 1'b1;
                    tbl_wr_idx   = r_clr_cnt;
                    tbl_wr_state = INIT_STATE;
                    w_push       = w_accept;
                end else if (!w_empty) begin
                    tbl_rd_idx   = r_fifo_idx[r_rd_ptr];
                    tbl_wr_en    = 1'b1;
                    tbl_wr_idx   = r_fifo_idx[r_rd_ptr];
                    tbl_wr_state = sat_step(tbl_rd_state, r_fifo_taken[r_rd_ptr]);
                    w_pop        = 1'b1;
                    w_push       = w_accept;
                end
`ifdef BP_UPD_BYPASS_EN
                else if (w_accept) begin
                    // Empty FIFO: write the incoming update straight through.
                    tbl_rd_idx   = w_upd_idx;
                    tbl_wr_en    = 1'b1;
                    tbl_wr_idx   = w_upd_idx;
                    tbl_wr_state = sat_step(tbl_rd_state, upd_taken);
                end
`endif
                else begin
                    w_push = w_accept;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state   <= ST_CLEAR;
            r_clr_cnt <= '0;
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
        end else if (rdy) begin
            if (clr_req) begin
                r_state   <= ST_CLEAR;
                r_clr_cnt <= '0;
                r_wr_ptr  <= '0;
                r_rd_ptr  <= '0;
                r_count   <= '0;
            end else begin
                if (r_state == ST_CLEAR) begin
                    // Counter wraps to 0 naturally after the last index.
                    r_clr_cnt <= r_clr_cnt + IDX_W'(1);
                    if (&r_clr_cnt) begin
                        r_state <= ST_RUN;
                    end
                end
                if (w_push) begin
                    r_fifo_idx[r_wr_ptr]   <= w_upd_idx;
                    r_fifo_taken[r_wr_ptr] <= upd_taken;
                    r_wr_ptr               <= r_wr_ptr + 1'b1;
                end
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + 1'b1;
                end
                case ({w_push, w_pop})
                    2'b10:   r_count <= r_count + 1'b1;
                    2'b01:   r_count <= r_count - 1'b1;
                    default: r_count <= r_count;
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_bp_update_sched.sv
`default_nettype none
// ============================================================================
//  Module   : tb_bp_update_sched
//  Purpose  : Self-checking bench for bp_update_sched (IDX_W=4, FIFO_DEPTH=4).
//             Holds a 16-entry table model driven by the DUT write port and
//             read back combinationally. Expected drain writes are queued when
//             an update is accepted and compared when the DUT writes in RUN.
//             Builds with or without BP_UPD_BYPASS_EN.
//  Revision : 1.0  initial release
// ============================================================================
module tb_bp_update_sched;

    localparam int IDX_W = 4;

    typedef struct {
        logic [31:0] pc;
        logic        taken;
        logic [3:0]  idx;
        logic [1:0]  st;
    } vec_t;

    typedef struct {
        logic [3:0] idx;
        logic [1:0] st;
    } exp_t;

    logic             clk;
    logic             rst;
    logic             rdy;
    logic             upd_valid;
    logic [31:0]      upd_pc;
    logic             upd_taken;
    logic             upd_ready;
    logic             clr_req;
    logic [IDX_W-1:0] tbl_rd_idx;
    logic [1:0]       tbl_rd_state;
    logic             tbl_wr_en;
    logic [IDX_W-1:0] tbl_wr_idx;
    logic [1:0]       tbl_wr_state;
    logic             busy;

    logic [1:0] mem [16];
    exp_t       sb [$];
    vec_t       vecs [10];
    int         n_tests = 0;
    int         n_fail  = 0;

    bp_update_sched #(
        .IDX_W      (IDX_W),
        .FIFO_DEPTH (4),
        .INIT_STATE (2'b01)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .rdy          (rdy),
        .upd_valid    (upd_valid),
        .upd_pc       (upd_pc),
        .upd_taken    (upd_taken),
        .upd_ready    (upd_ready),
        .clr_req      (clr_req),
        .tbl_rd_idx   (tbl_rd_idx),
        .tbl_rd_state (tbl_rd_state),
        .tbl_wr_en    (tbl_wr_en),
        .tbl_wr_idx   (tbl_wr_idx),
        .tbl_wr_state (tbl_wr_state),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Predictor table model.
    always @(posedge clk) begin
        if (tbl_wr_en) begin
            mem[tbl_wr_idx] <= tbl_wr_state;
        end
    end
    assign tbl_rd_state = mem[tbl_rd_idx];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic idle_inputs();
        rdy       = 1'b1;
        upd_valid = 1'b0;
        upd_pc    = 32'h0;
        upd_taken = 1'b0;
        clr_req   = 1'b0;
    endtask

    // Queue the expected write for an update the DUT accepted this cycle.
    task automatic note_push(input logic [3:0] idx, input logic [1:0] st);
        exp_t e;
        if (upd_valid && upd_ready) begin
            e.idx = idx;
            e.st  = st;
            sb.push_back(e);
        end
    endtask

    // Any table write outside a sweep must match the oldest expected update.
    task automatic monitor();
        exp_t e;
        if (tbl_wr_en && !busy) begin
            if (sb.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL sb_unexpected_write: got write idx %0d state %0d, expected none",
                         tbl_wr_idx, tbl_wr_state);
            end else begin
                e = sb.pop_front();
                chk("sb_wr_idx", 32'(tbl_wr_idx), 32'(e.idx));
                chk("sb_rd_idx", 32'(tbl_rd_idx), 32'(e.idx));
                chk("sb_wr_state", 32'(tbl_wr_state), 32'(e.st));
            end
        end
    endtask

    // Inputs are set at posedge+1, checks at posedge+3, then on to the next cycle.
    task automatic step();
        monitor();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_cycle();
        idle_inputs();
        rst       = 1'b0;
        upd_valid = 1'b1;
        upd_pc    = 32'h10;
        #2;
        chk("rst_busy", 32'(busy), 32'd1);
        chk("rst_wr_en", 32'(tbl_wr_en), 32'd0);
        chk("rst_upd_ready", 32'(upd_ready), 32'd0);
        chk("rst_rd_idx", 32'(tbl_rd_idx), 32'd0);
        chk("rst_wr_idx", 32'(tbl_wr_idx), 32'd0);
        chk("rst_wr_state", 32'(tbl_wr_state), 32'd0);
        step();
        rst = 1'b1;
    endtask

    // Full 16-entry sweep. The first n_push cycles offer updates to idx 1..n_push
    // (even k taken); a clr_req at cycle clr_at restarts the expected index at 0.
    task automatic sweep(input int n_push, input int clr_at);
        int c = 0;
        int k = 0;
        while (c < 16) begin
            idle_inputs();
            if (k < n_push) begin
                upd_valid = 1'b1;
                upd_pc    = 32'((k + 1) * 4);
                upd_taken = (k % 2 == 0);
            end
            if (k == clr_at) clr_req = 1'b1;
            #2;
            if (clr_req) begin
                chk("sweep_clr_busy", 32'(busy), 32'd1);
                chk("sweep_clr_ready", 32'(upd_ready), 32'd0);
                c = 0;
            end else begin
                chk("sweep_busy", 32'(busy), 32'd1);
                chk("sweep_wr_en", 32'(tbl_wr_en), 32'd1);
                chk("sweep_wr_idx", 32'(tbl_wr_idx), 32'(c));
                chk("sweep_wr_state", 32'(tbl_wr_state), 32'd1);
                c++;
            end
            if (k < n_push) begin
                chk("sweep_push_ready", 32'(upd_ready), 32'(k < 4));
                note_push(4'(k + 1), upd_taken ? 2'b10 : 2'b00);
            end
            step();
            k++;
        end
        chk("sweep_done_busy", 32'(busy), 32'd0);
    endtask

    initial begin
        vecs[0] = '{32'h10, 1'b1, 4'd4,  2'b10};
        vecs[1] = '{32'h10, 1'b1, 4'd4,  2'b11};
        vecs[2] = '{32'h10, 1'b1, 4'd4,  2'b11};
        vecs[3] = '{32'h10, 1'b0, 4'd4,  2'b10};
        vecs[4] = '{32'h10, 1'b0, 4'd4,  2'b01};
        vecs[5] = '{32'h10, 1'b0, 4'd4,  2'b00};
        vecs[6] = '{32'h10, 1'b0, 4'd4,  2'b00};
        vecs[7] = '{32'h24, 1'b1, 4'd9,  2'b10};
        vecs[8] = '{32'h3C, 1'b0, 4'd15, 2'b00};
        vecs[9] = '{32'h40, 1'b1, 4'd0,  2'b10};

        rst = 1'b0;
        idle_inputs();
        @(posedge clk);
        #1;

        // Reset outputs, then the power-on sweep.
        reset_cycle();
        reset_cycle();
        sweep(0, -1);
        idle_inputs();
        #2;
        chk("post_sweep_wr_en", 32'(tbl_wr_en), 32'd0);
        step();

        // Saturating updates, back-to-back.
        for (int i = 0; i < 10; i++) begin
            idle_inputs();
            upd_valid = 1'b1;
            upd_pc    = vecs[i].pc;
            upd_taken = vecs[i].taken;
            #2;
            chk("vec_ready", 32'(upd_ready), 32'd1);
            note_push(vecs[i].idx, vecs[i].st);
            step();
        end
        for (int i = 0; i < 2; i++) begin
            idle_inputs();
            #2;
            step();
        end
        chk("vec_drained", 32'(sb.size()), 32'd0);

        // Five updates offered during a reset sweep: four held, drained in order.
        reset_cycle();
        sweep(5, -1);
        for (int i = 0; i < 4; i++) begin
            idle_inputs();
            #2;
            chk("held_drain_wr_en", 32'(tbl_wr_en), 32'd1);
            step();
        end
        idle_inputs();
        #2;
        chk("held_drain_done", 32'(tbl_wr_en), 32'd0);
        step();

        // rdy=0 freeze with two queued entries.
        idle_inputs();
        clr_req = 1'b1;
        #2;
        chk("clr_run_wr_en", 32'(tbl_wr_en), 32'd0);
        step();
        sweep(2, -1);
        for (int i = 0; i < 3; i++) begin
            idle_inputs();
            rdy       = 1'b0;
            upd_valid = 1'b1;
            upd_pc    = 32'h30;
            #2;
            chk("freeze_wr_en", 32'(tbl_wr_en), 32'd0);
            chk("freeze_ready", 32'(upd_ready), 32'd0);
            chk("freeze_busy", 32'(busy), 32'd0);
            step();
        end
        for (int i = 0; i < 2; i++) begin
            idle_inputs();
            #2;
            chk("resume_wr_en", 32'(tbl_wr_en), 32'd1);
            step();
        end

        // clr_req in RUN with three queued plus a new update, then a restart mid-sweep.
        idle_inputs();
        clr_req = 1'b1;
        #2;
        step();
        sweep(3, -1);
        idle_inputs();
        clr_req   = 1'b1;
        upd_valid = 1'b1;
        upd_pc    = 32'h20;
        upd_taken = 1'b1;
        #2;
        chk("clr_drop_ready", 32'(upd_ready), 32'd0);
        chk("clr_head_wr_en", 32'(tbl_wr_en), 32'd0);
        chk("clr_busy", 32'(busy), 32'd0);
        sb.delete();
        step();
        sweep(0, 7);
        idle_inputs();
        #2;
        chk("flushed_no_drain", 32'(tbl_wr_en), 32'd0);
        step();

        // Latency of a lone update into an empty FIFO.
        idle_inputs();
        upd_valid = 1'b1;
        upd_pc    = 32'h8;
        upd_taken = 1'b1;
        #2;
        chk("lone_ready", 32'(upd_ready), 32'd1);
        note_push(4'd2, 2'b10);
`ifdef BP_UPD_BYPASS_EN
        chk("byp_wr_en", 32'(tbl_wr_en), 32'd1);
        chk("byp_wr_idx", 32'(tbl_wr_idx), 32'd2);
        chk("byp_wr_state", 32'(tbl_wr_state), 32'd2);
        step();
        idle_inputs();
        #2;
        chk("byp_next_wr_en", 32'(tbl_wr_en), 32'd0);
        step();
`else
        chk("fifo_same_wr_en", 32'(tbl_wr_en), 32'd0);
        step();
        idle_inputs();
        #2;
        chk("fifo_next_wr_en", 32'(tbl_wr_en), 32'd1);
        chk("fifo_next_wr_idx", 32'(tbl_wr_idx), 32'd2);
        chk("fifo_next_wr_state", 32'(tbl_wr_state), 32'd2);
        step();
`endif
        chk("sb_empty_at_end", 32'(sb.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
